// File: rtl/sync_frame_tx.sv
// sync_frame_tx: 1101 sync-word serial transmitter with 0-bit stuffing.
// Define SYNC_FRAME_TX_PARITY_EN to append a stuffed even-parity bit.
module sync_frame_tx #(
    parameter int DATA_W  = 8,
    parameter int GAP_LEN = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(GAP_LEN + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
    localparam logic [CW-1:0] ALL_BITS = CW'(DATA_W);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_LEN - 1);

`ifdef SYNC_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, SYNC, DATA, STUFF, GAP, PARITY
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, SYNC, DATA, STUFF, GAP
    } state_t;
`endif

    // state names the source of the next bit to drive
    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        hist;
    logic [CW-1:0]     bit_cnt;
    logic [1:0]        sync_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              data_bit;
    logic              sync_bit;
    logic              stuff_data;

`ifdef SYNC_FRAME_TX_PARITY_EN
    logic parity;
    logic par_sent;
    logic stuff_par;
    assign stuff_par = (hist[1:0] == 2'b11) && !parity;
`endif

    assign data_bit   = shreg[DATA_W-1];
    assign sync_bit   = (sync_cnt != 2'd1);
    assign stuff_data = (hist[1:0] == 2'b11) && !data_bit;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            out        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_ready   <= 1'b0;
            shreg      <= '0;
            hist       <= 3'b000;
            bit_cnt    <= '0;
            sync_cnt   <= '0;
            gap_cnt    <= '0;
`ifdef SYNC_FRAME_TX_PARITY_EN
            parity     <= 1'b0;
            par_sent   <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    out  <= 1'b0;
                    busy <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        shreg    <= tx_data;
                        bit_cnt  <= '0;
                        sync_cnt <= '0;
                        gap_cnt  <= '0;
                        out      <= 1'b1;
                        hist     <= {hist[1:0], 1'b1};
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        state    <= SYNC;
`ifdef SYNC_FRAME_TX_PARITY_EN
                        parity   <= ^tx_data;
                        par_sent <= 1'b0;
`endif
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                SYNC: begin
                    out      <= sync_bit;
                    hist     <= {hist[1:0], sync_bit};
                    sync_cnt <= sync_cnt + 2'd1;
                    if (sync_cnt == 2'd2)
                        state <= DATA;
                end
                DATA: begin
                    out     <= data_bit;
                    hist    <= {hist[1:0], data_bit};
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (stuff_data)
                        state <= STUFF;
                    else if (bit_cnt == LAST_BIT)
`ifdef SYNC_FRAME_TX_PARITY_EN
                        state <= PARITY;
`else
                        state <= GAP;
`endif
                end
                STUFF: begin
                    out  <= 1'b0;
                    hist <= {hist[1:0], 1'b0};
                    if (bit_cnt != ALL_BITS)
                        state <= DATA;
`ifdef SYNC_FRAME_TX_PARITY_EN
                    else if (!par_sent)
                        state <= PARITY;
`endif
                    else
                        state <= GAP;
                end
`ifdef SYNC_FRAME_TX_PARITY_EN
                PARITY: begin
                    out      <= parity;
                    hist     <= {hist[1:0], parity};
                    par_sent <= 1'b1;
                    state    <= stuff_par ? STUFF : GAP;
                end
`endif
                GAP: begin
                    out  <= 1'b0;
                    hist <= {hist[1:0], 1'b0};
                    if (gap_cnt == LAST_GAP) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: directed + random frames against a bit-list model
// of the 1101 framing, stuffing and gap rules.
module tb_sync_frame_tx;

    localparam int DATA_W  = 8;
    localparam int GAP_LEN = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              tx_valid = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_ready;
    logic              out;
    logic              busy;
    logic              frame_done;

    int n_checks = 0;
    int n_fail = 0;
    int hits = 0;
    logic [2:0] det = 3'b000;
    bit exp_q[$];

    sync_frame_tx #(.DATA_W(DATA_W), .GAP_LEN(GAP_LEN)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .out       (out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    // receiver-side overlapping 1101 detector
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if ({det, out} == 4'b1101)
                hits <= hits + 1;
            det <= {det[1:0], out};
        end else begin
            det <= 3'b000;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_payload(input bit b);
        int n;
        exp_q.push_back(b);
        n = exp_q.size();
        if (exp_q[n-3] && exp_q[n-2] && !exp_q[n-1])
            exp_q.push_back(1'b0);
    endfunction

    function automatic void build(input logic [DATA_W-1:0] d);
        exp_q = {1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = DATA_W - 1; i >= 0; i--)
            push_payload(d[i]);
`ifdef SYNC_FRAME_TX_PARITY_EN
        push_payload(^d);
`endif
        for (int i = 0; i < GAP_LEN; i++)
            exp_q.push_back(1'b0);
    endfunction

    // entered and left at posedge+1
    task automatic idle(input int n);
        tx_valid = 1'b0;
        repeat (n) begin
            @(negedge sys_clk);
            check("idle_out", out, 0);
            check("idle_busy", busy, 0);
            check("idle_ready", tx_ready, 1);
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_frame(input logic [DATA_W-1:0] d, input bit hold);
        int k;
        int h0;
        build(d);
        tx_valid = 1'b1;
        tx_data  = d;
        k = 0;
        while (!tx_ready && k < 40) begin
            @(negedge sys_clk);
            k++;
        end
        check("accept_wait", k, 0);
        @(posedge sys_clk);
        h0 = hits;
        #1;
        tx_valid = hold;
        tx_data  = DATA_W'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge sys_clk);
            check("out_bit", out, exp_q[i]);
            check("frame_done", frame_done, (i == exp_q.size() - 1));
            if (i == 0) begin
                check("busy_in_frame", busy, 1);
                check("ready_in_frame", tx_ready, 0);
            end
        end
        @(posedge sys_clk);
        #1;
        check("sync_hits", hits - h0, 1);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        #3;
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", tx_ready, 0);
        check("rst_done", frame_done, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check("rel_ready", tx_ready, 1);
        check("rel_out", out, 0);

        run_frame(8'h00, 1'b0);
        idle(1);
        run_frame(8'hB6, 1'b0);
        idle(2);
        run_frame(8'hFF, 1'b0);
        idle(1);
        run_frame(8'h01, 1'b0);
        idle(1);
        run_frame(8'hB6, 1'b1);
        run_frame(8'h6D, 1'b0);
        idle(1);

        // abort mid-payload
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(posedge sys_clk);
        #1;
        tx_valid = 1'b0;
        repeat (7) @(negedge sys_clk);
        check("pre_abort_out", out, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("abort_out", out, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", tx_ready, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check("abort_rel_ready", tx_ready, 1);
        run_frame(8'h6D, 1'b0);

        for (int r = 0; r < 16; r++) begin
            d = DATA_W'($urandom);
            if (r % 4 == 3)
                d = 8'hB6 ^ DATA_W'($urandom_range(0, 3));
            run_frame(d, ($urandom_range(0, 1) == 1));
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
- Serial frame transmitter: the sending end of the "1101" sync-word serial link.
- Accepts a parallel payload word and emits one bit per clock on `out`: sync word 1101, then payload MSB-first with 0-bit stuffing, then a zero gap.
- Stuffing guarantees the receiver's overlapping 1101 detector fires only on a real sync word.
- Sits between a parallel producer and the single-wire link.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- GAP_LEN, 2, number of forced 0 bits after each frame (>=1).

Ports:
- sys_clk  input  1  clock; all state changes on rising edge.
- sys_rst_n  input  1  reset, asynchronous, active-low.
- tx_valid  input  1  producer has a word on tx_data.
- tx_data  input  DATA_W  payload word; sampled only on the accept cycle.
- tx_ready  output  1  block can accept a word (high only in IDLE).
- out  output  1  serial line, registered.
- busy  output  1  frame in progress (any state except IDLE).
- frame_done  output  1  one-cycle pulse on the cycle the last gap bit is driven on `out`.

Behaviour:
- Reset (async, sys_rst_n=0): state=IDLE, out=0, busy=0, frame_done=0, tx_ready=0 while reset asserted. Reset also clears the bit history hist[2:0] to 000. Reset mid-frame aborts the frame immediately, with no completion of remaining bits.
- Accept: tx_valid && tx_ready at a rising edge. The word is captured into a shift register. The first sync bit '1' appears on `out` in the following cycle. tx_ready is 1 in IDLE after reset release, else 0.
- One bit per cycle on `out`. hist holds the last three bits driven, newest in hist[0], and shifts on every driven bit in every state, including sync and gap bits. hist does not shift in IDLE.
- States:
  - IDLE: out=0; on accept go to SYNC.
  - SYNC: drive 1,1,0,1 over 4 cycles, then go to DATA. With PARITY_EN defined, a PARITY state follows the last data bit; see Optional Feature.
  - DATA: drive the next payload bit, MSB first. If hist, after including this bit, equals 110, go to STUFF. Otherwise continue DATA. After the last payload bit with no stuff required, go to GAP.
  - STUFF: drive 0 for one cycle. Then resume DATA, or go to GAP if the payload is exhausted. A stuff triggered by the final data bit is still emitted before GAP.
  - GAP: drive 0 for GAP_LEN cycles. frame_done=1 on the final gap cycle. Next state is IDLE.
- Stuffing applies only to DATA and PARITY bits; sync bits and gap bits are never stuffed.
- Frame length = 4 + DATA_W + (number of stuffs) + GAP_LEN cycles from first sync bit to last gap bit.
- Back-to-back: at least one IDLE cycle (out=0) exists between frames. The earliest next first-sync bit is 2 cycles after frame_done.
- tx_valid held high with changing tx_data while busy has no effect.
- Bit counter width: clog2(DATA_W+1). Payload bit counter counts only payload bits, not stuffs.

Optional Feature:
- Macro: SYNC_FRAME_TX_PARITY_EN.
- Defined: after the last payload bit, a PARITY state drives the even-parity bit (XOR of all DATA_W payload bits, computed at accept). The parity bit is subject to the same 110 stuffing rule, then the FSM goes to GAP. Frame length increases by 1.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STUFF/GAP.

Test Plan:
- Reset: assert sys_rst_n=0 asynchronously mid-cycle -> out=0, busy=0, tx_ready=0 immediately; after release tx_ready=1, out=0.
- DATA_W=8, GAP_LEN=2, tx_data=8'h00 -> out = 1101 00000000 00 (14 cycles). frame_done on the 14th bit. No stuffs.
- tx_data=8'hB6 (10110110) -> out = 1101 1 0 0 1 1 0 0 1 1 0 0 00, with stuff 0 after each "110" (3 stuffs). 17 cycles total; stuff after final bit precedes gap.
- tx_data=8'hFF -> out = 1101 11111111 00, no stuffs. A bench-side 1101 detector fires exactly once per frame, on the sync.
- Back-to-back: tx_valid held 1 with 8'hB6 then 8'h6D -> second sync starts 2 cycles after first frame_done. The detector fires exactly twice, with no payload hits.
- Reset mid-DATA (after 3 payload bits) -> out=0 immediately. After release, a new accept yields a clean 1101 sync with hist restarted from 000.
- With SYNC_FRAME_TX_PARITY_EN, tx_data=8'h01 -> out = 1101 00000001 1 00 (parity 1 after LSB, hist 011, no stuff). 15 cycles.
